// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: multiplexes one BIN decoder
// across DIGITS common-anode digits with dead-time and LZ blanking.
module seg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic                  LZ_BLANK,
  output logic [3:0]            DIG_BIN,
  output logic [DIGITS-1:0]     AN,
  output logic                  FRAME,
  output logic                  PEND
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic {
    OFF,
    SCAN
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic                pend_q, pend_d;
  logic                frame_q, frame_d;
  logic [3:0]          dig_bin_q, dig_bin_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick;
  logic                last;
  logic                xfer;
  logic                any_nz;
  logic [DIGITS-1:0]   lit;

  assign tick = (pcnt_q == PW'(PRESCALE - 1));
  assign last = (idx_q == IW'(DIGITS - 1));

  // State and registered outputs; reset drops everything incl. pending
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= OFF;
      pcnt_q    <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      frame_q   <= 1'b0;
      dig_bin_q <= 4'd0;
      an_q      <= '1;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      frame_q   <= frame_d;
      dig_bin_q <= dig_bin_d;
      an_q      <= an_d;
    end
  end

  // Next state: slot counters, frame boundary, buffer transfer
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    idx_d   = idx_q;
    frame_d = 1'b0;
    xfer    = 1'b0;
    unique case (state_q)
      OFF: begin
        pcnt_d = '0;
        idx_d  = '0;
        if (EN) begin
          state_d = SCAN;
          xfer    = pend_q;
        end
      end
      SCAN: begin
        if (!EN) begin
          state_d = OFF;
          pcnt_d  = '0;
          idx_d   = '0;
        end else if (tick) begin
          pcnt_d  = '0;
          idx_d   = last ? '0 : idx_q + 1'b1;
          frame_d = last;
          xfer    = pend_q & last;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: state_d = OFF;
    endcase
    active_d  = xfer ? pending_q : active_q;
    pending_d = LOAD ? VALUE : pending_q;
    pend_d    = LOAD | (pend_q & ~xfer);
  end

  // Outputs for the upcoming cycle, from next-state values
  always_comb begin
    any_nz    = 1'b0;
    lit       = '0;
    dig_bin_d = 4'd0;
    an_d      = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz = any_nz | (active_d[4*i +: 4] != 4'd0);
      lit[i] = any_nz | (i == 0) | ~LZ_BLANK;
    end
    if (state_d == SCAN) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_d == IW'(i)) begin
          dig_bin_d = active_d[4*i +: 4];
          if (pcnt_d >= PW'(DEAD) && lit[i])
            an_d[i] = 1'b0;
        end
      end
    end
  end

  assign DIG_BIN = dig_bin_q;
  assign AN      = an_q;
  assign FRAME   = frame_q;
  assign PEND    = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a time-based reference
// model predicts each cycle's outputs; a monitor compares them.
module tb_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int D  = 2;
  localparam int FP = N * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        lz = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dig_bin;
  logic [3:0]  an;
  logic        frame;
  logic        pend;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS(N),
    .PRESCALE(P),
    .DEAD(D)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .EN(en),
    .LOAD(load),
    .VALUE(value),
    .LZ_BLANK(lz),
    .DIG_BIN(dig_bin),
    .AN(an),
    .FRAME(frame),
    .PEND(pend)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] dig;
    logic       frame;
    logic       pend;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: scan time mt counts cycles since scanning began
  bit          m_scan = 0;
  int          mt = 0;
  logic [15:0] m_active = 16'h0;
  logic [15:0] m_pending = 16'h0;
  bit          m_pend = 0;
  bit          m_frame = 0;

  task automatic step(input bit r, input bit e, input bit l,
                      input logic [15:0] v, input bit z);
    exp_t        x;
    int          slot;
    int          ph;
    logic [15:0] upper;
    @(negedge clk);
    rst_n = r;
    en    = e;
    load  = l;
    value = v;
    lz    = z;
    if (!r) begin
      m_scan    = 0;
      mt        = 0;
      m_active  = 16'h0;
      m_pending = 16'h0;
      m_pend    = 0;
      m_frame   = 0;
    end else begin
      m_frame = 0;
      if (!m_scan) begin
        if (e) begin
          m_scan = 1;
          mt     = 0;
          if (m_pend) begin
            m_active = m_pending;
            m_pend   = 0;
          end
        end
      end else if (!e) begin
        m_scan = 0;
        mt     = 0;
      end else begin
        mt = mt + 1;
        if (mt % FP == 0) begin
          m_frame = 1;
          if (m_pend) begin
            m_active = m_pending;
            m_pend   = 0;
          end
        end
      end
      if (l) begin
        m_pending = v;
        m_pend    = 1;
      end
    end
    x.an    = 4'hF;
    x.dig   = 4'h0;
    x.frame = m_frame;
    x.pend  = m_pend;
    if (m_scan) begin
      slot  = (mt / P) % N;
      ph    = mt % P;
      upper = m_active >> (4 * slot);
      x.dig = upper[3:0];
      if (ph >= D && (slot == 0 || !z || upper != 16'h0))
        x.an[slot] = 1'b0;
    end
    sb.push_back(x);
  endtask

  // Monitor: one expected vector per clock edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        vectors++;
        if ({an, dig_bin, frame, pend} !== x) begin
          miscompares++;
          $display("FAIL out t=%0t got AN=%b DIG=%h FRAME=%b PEND=%b want AN=%b DIG=%h FRAME=%b PEND=%b",
                   $time, an, dig_bin, frame, pend,
                   x.an, x.dig, x.frame, x.pend);
        end
      end
    end
  end

  function automatic logic [15:0] rnd_val();
    logic [15:0] v;
    v = 16'h0;
    for (int i = 0; i < N; i++)
      if ($urandom_range(0, 1) == 1)
        v[4*i +: 4] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    bit re;
    bit rz;
    // Reset held with EN and LOAD asserted
    repeat (3) step(0, 1, 1, 16'hFFFF, 0);
    // Load in OFF, then scan 1234
    step(1, 0, 1, 16'h1234, 0);
    repeat (70) step(1, 1, 0, 16'h0, 0);
    // Double buffer: mid-frame load
    for (int k = 0; k < 100 && (mt % FP) != 13; k++)
      step(1, 1, 0, 16'h0, 0);
    step(1, 1, 1, 16'hABCD, 0);
    repeat (70) step(1, 1, 0, 16'h0, 0);
    // Leading-zero blanking
    step(1, 1, 1, 16'h0050, 1);
    repeat (70) step(1, 1, 0, 16'h0, 1);
    step(1, 1, 1, 16'h0000, 1);
    repeat (70) step(1, 1, 0, 16'h0, 1);
    // LOAD coincident with the frame wrap
    for (int k = 0; k < 100 && (mt % FP) != 2; k++)
      step(1, 1, 0, 16'h0, 0);
    step(1, 1, 1, 16'h1111, 0);
    for (int k = 0; k < 100 && (mt % FP) != FP - 1; k++)
      step(1, 1, 0, 16'h0, 0);
    step(1, 1, 1, 16'h2222, 0);
    repeat (70) step(1, 1, 0, 16'h0, 0);
    // EN drop at slot 2, PCNT 5
    for (int k = 0; k < 100 && (mt % FP) != 2 * P + 5; k++)
      step(1, 1, 0, 16'h0, 0);
    repeat (5) step(1, 0, 0, 16'h0, 0);
    repeat (20) step(1, 1, 0, 16'h0, 0);
    // Randomized traffic
    re = 1;
    rz = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) re = ~re;
      if ($urandom_range(0, 99) == 0) rz = ~rz;
      step($urandom_range(0, 199) != 0, re,
           $urandom_range(0, 15) == 0, rnd_val(), rz);
    end
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
